sdram_responder: RTL
====================

Name: sdram_responder

Overview:
Synthesizable SDRAM device emulator: the memory-chip end of the SDRAM command bus driven by SDRAMController. It decodes CS/RAS/CAS/WE commands and tracks per-bank open-row state. It backs reads and writes with a small on-chip word array. Used for FPGA loopback bring-up and as the simulation target for the controller; it flags protocol and timing violations.

Parameters:
ClockFrequency, 12000000, clk frequency in Hz; timing ns→clocks via Clocks(t)=(t*ClockFrequency)/1e9
CAS, 2, read latency in clocks (2 or 3)
MemAddrWidth, 10, backing-array depth = 2**MemAddrWidth 16-bit words
TRCD, 21, min ns ACTIVATE→READ/WRITE, same bank
TRP, 21, min ns precharge→ACTIVATE, same bank
TWR, 14, write recovery ns before auto-precharge starts
TREFI, 15625, max ns between AUTO REFRESH commands

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
sdram_cke  in  1  clock enable; 0 forces NOP decode
sdram_ba  in  2  bank address
sdram_a  in  12  row / {a10, col[8:0]} / mode
sdram_cs_  in  1  chip select, active-low
sdram_ras_  in  1  row strobe, active-low
sdram_cas_  in  1  column strobe, active-low
sdram_we_  in  1  write enable, active-low
sdram_ldqm  in  1  low-byte mask (1 = masked)
sdram_udqm  in  1  high-byte mask
dq_in  in  16  write data from pad
dq_out  out  16  read data to pad
dq_oe  out  1  pad output enable
err  out  1  sticky violation flag
errCode  out  3  code of first violation

Behaviour:
- Reset (async, rst=1): all banks Idle, timers 0, read pipeline empty, dq_oe=0, dq_out=0, err=0, errCode=0, refresh timer=Clocks(TREFI). Array contents are not reset. Reset mid-read drops pending data; dq_oe falls at once.
- Decoding is on the rising edge. Command = {ras_,cas_,we_}, valid only when cs_=0 and cke=1; otherwise NOP.
  - 111 NOP.
  - 011 ACTIVATE: bank[ba] Idle→Active, row=a.
  - 101 READ / 100 WRITE: column a[8:0]; a10=1 auto-precharge.
  - 010 PRECHARGE: a10=1 all banks.
  - 001 AUTO REFRESH.
  - 000 LOAD MODE.
- Array index = {ba,row,col}[MemAddrWidth-1:0]. Higher bits alias.
- WRITE: dq_in is sampled on the command edge. The low byte is written unless ldqm=1; the high byte unless udqm=1. Burst length 1.
- READ latency: READ sampled at edge k → dq_out/dq_oe registered at edge k+CAS-1, held exactly one cycle, so the initiator samples at edge k+CAS. The read path is a CAS-deep shift pipeline, so back-to-back READs on consecutive cycles yield consecutive data.
- Read-during-write same address: a READ returns the array content as of its command edge. A WRITE on the preceding edge is visible.
- Auto-precharge: bank→Idle after the command. It is busy Clocks(TRP) clocks after a READ, or Clocks(TWR)+Clocks(TRP) clocks after a WRITE.
- PRECHARGE to an Idle bank is legal (no-op). LOAD MODE latches a[6:4]; a value ≠ CAS → error 6.
- Errors are first-wins. err/errCode latch until reset; later violations are ignored. Offending commands still execute where defined (READ/WRITE to an Idle bank does nothing).
  - 1: READ/WRITE to an Idle bank.
  - 2: ACTIVATE to an Active bank.
  - 6: mode CAS mismatch.
  - 7: WRITE issued while dq_oe will be high on that edge (bus contention).
- Simultaneous error sources on one edge: lowest code wins.

Optional Feature:
SDRAM_RESPONDER_TIMING_CHECK_EN.
- Defined: per-bank and refresh timers are checked.
  - 3: READ/WRITE before Clocks(TRCD) since ACTIVATE.
  - 4: ACTIVATE while the bank is still in tRP/tWR busy time.
  - 5: refresh timer reaches 0. Each AUTO REFRESH reloads it to Clocks(TREFI). AUTO REFRESH with any bank Active is also code 5.
- Undefined: timers are not built; codes 3–5 never occur. Banks become Idle immediately on precharge.
- A timing value whose Clocks() is 0 disables that check.

Decomposition:
- Package sdram_pkg: command encodings (CmdNop, CmdBankActivate, CmdRead, CmdWrite, CmdPrecharge, CmdRefresh, CmdLoadMode), the Clocks function, and error-code constants. SDRAMController migrates to it.
- Sub-module sdram_responder_bank: one bank's Idle/Active state, open row, and tRCD/tRP busy counters. Instantiated 4×.

Test Plan:
- WRITE bank1 row 0x012 col 0x005 data 0xA5C3, then READ same (CAS=2) → dq_oe=1 with dq_out=0xA5C3 exactly at the READ edge+2 sample point; err=0.
- WRITE 0xFFFF then WRITE 0x1234 with ldqm=1, then READ → 0x12FF.
- READ bank2 with no prior ACTIVATE → err=1, errCode=1, dq_oe stays 0. Then ACTIVATE bank0 twice → errCode still 1 (first-wins).
- Three READs on consecutive edges to cols 0,1,2 holding 0x0001/0x0002/0x0003 → three consecutive dq_out cycles 0x0001,0x0002,0x0003.
- TIMING_CHECK_EN, ClockFrequency=100000000: ACTIVATE then READ 1 cycle later (Clocks(TRCD)=2) → errCode=3. Fresh run with no refresh for 1563 clocks → errCode=5.
- rst asserted asynchronously mid-cycle between READ and its data → dq_oe=0 immediately; no data appears after release; bank0 Idle (next READ → errCode=1).

Source files
------------

// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - SDRAM command encodings, bank states, error codes and ns-to-clock conversion
package sdram_pkg;

  typedef enum logic [2:0] {
    CmdLoadMode     = 3'b000,
    CmdRefresh      = 3'b001,
    CmdPrecharge    = 3'b010,
    CmdBankActivate = 3'b011,
    CmdWrite        = 3'b100,
    CmdRead         = 3'b101,
    CmdBurstTerm    = 3'b110,
    CmdNop          = 3'b111
  } sdram_cmd_t;

  typedef enum logic {
    BankIdle   = 1'b0,
    BankActive = 1'b1
  } bank_state_t;

  localparam logic [2:0] ErrNone       = 3'd0;
  localparam logic [2:0] ErrIdleBank   = 3'd1;
  localparam logic [2:0] ErrActiveBank = 3'd2;
  localparam logic [2:0] ErrTrcd       = 3'd3;
  localparam logic [2:0] ErrBankBusy   = 3'd4;
  localparam logic [2:0] ErrRefresh    = 3'd5;
  localparam logic [2:0] ErrModeCas    = 3'd6;
  localparam logic [2:0] ErrContention = 3'd7;

  // Truncating conversion; a result of 0 means the corresponding check is off.
  function automatic int Clocks(input longint unsigned t_ns, input longint unsigned freq_hz);
    return 32'((t_ns * freq_hz) / 64'd1000000000);
  endfunction

endpackage

// File: rtl/sdram_responder_if.sv
// rtl/sdram_responder_if.sv - SDRAM command/data pin bundle between controller (master) and device (slave)
interface sdram_responder_if;
  logic        sdram_cke;
  logic [1:0]  sdram_ba;
  logic [11:0] sdram_a;
  logic        sdram_cs_;
  logic        sdram_ras_;
  logic        sdram_cas_;
  logic        sdram_we_;
  logic        sdram_ldqm;
  logic        sdram_udqm;
  logic [15:0] dq_in;
  logic [15:0] dq_out;
  logic        dq_oe;

  modport master (
    output sdram_cke, sdram_ba, sdram_a, sdram_cs_, sdram_ras_, sdram_cas_, sdram_we_,
    output sdram_ldqm, sdram_udqm, dq_in,
    input  dq_out, dq_oe
  );

  modport slave (
    input  sdram_cke, sdram_ba, sdram_a, sdram_cs_, sdram_ras_, sdram_cas_, sdram_we_,
    input  sdram_ldqm, sdram_udqm, dq_in,
    output dq_out, dq_oe
  );
endinterface

// File: rtl/sdram_responder_bank.sv
// rtl/sdram_responder_bank.sv - one bank: Idle/Active state, open row, tRCD/tRP busy timers (SDRAM_RESPONDER_TIMING_CHECK_EN)
module sdram_responder_bank
  import sdram_pkg::*;
#(
  parameter int TrcdClk = 0,
  parameter int TrpClk  = 0,
  parameter int TwrClk  = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        activate,
  input  logic        precharge,
  input  logic        wr_recovery,
  input  logic [11:0] row_in,
  output logic        active,
  output logic [11:0] row,
  output logic        rcd_busy,
  output logic        rp_busy
);

  bank_state_t state, state_next;
  logic [11:0] row_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BankIdle;
      row   <= '0;
    end else begin
      state <= state_next;
      row   <= row_next;
    end
  end

  // ACTIVATE on an open bank keeps the current row; PRECHARGE on an idle bank is a no-op.
  always_comb begin
    state_next = state;
    row_next   = row;
    if (state == BankIdle) begin
      if (activate) begin
        state_next = BankActive;
        row_next   = row_in;
      end
    end else if (precharge) begin
      state_next = BankIdle;
    end
  end

  assign active = (state == BankActive);

`ifdef SDRAM_RESPONDER_TIMING_CHECK_EN
  // Counters hold the number of further edges on which the bank is still busy.
  localparam int RcdLoad   = (TrcdClk > 0) ? TrcdClk - 1 : 0;
  localparam int RpLoad    = (TrpClk > 0) ? TrpClk - 1 : 0;
  localparam int WrRpLoad  = (TrpClk > 0) ? TwrClk + TrpClk - 1 : 0;

  logic [15:0] rcd_cnt, rp_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcd_cnt <= '0;
      rp_cnt  <= '0;
    end else begin
      if (state == BankIdle && activate) rcd_cnt <= 16'(RcdLoad);
      else if (rcd_cnt != 16'd0)         rcd_cnt <= rcd_cnt - 16'd1;
      if (state == BankActive && precharge) rp_cnt <= wr_recovery ? 16'(WrRpLoad) : 16'(RpLoad);
      else if (rp_cnt != 16'd0)             rp_cnt <= rp_cnt - 16'd1;
    end
  end

  assign rcd_busy = (rcd_cnt != 16'd0);
  assign rp_busy  = (rp_cnt != 16'd0);
`else
  localparam int unused_timing = TrcdClk + TrpClk + TwrClk;
  logic unused_wr_recovery;
  assign unused_wr_recovery = wr_recovery;
  assign rcd_busy = 1'b0;
  assign rp_busy  = 1'b0;
`endif

endmodule

// File: rtl/sdram_responder.sv
// rtl/sdram_responder.sv - SDRAM device emulator with backing array and violation flag (SDRAM_RESPONDER_TIMING_CHECK_EN)
module sdram_responder
  import sdram_pkg::*;
#(
  parameter int ClockFrequency = 12000000,
  parameter int CAS            = 2,
  parameter int MemAddrWidth   = 10,
  parameter int TRCD           = 21,
  parameter int TRP            = 21,
  parameter int TWR            = 14,
  parameter int TREFI          = 15625
) (
  input  logic                clk,
  input  logic                rst,
  sdram_responder_if.slave    bus,
  output logic                err,
  output logic [2:0]          errCode
);

  localparam int TrcdClk = Clocks(TRCD, ClockFrequency);
  localparam int TrpClk  = Clocks(TRP, ClockFrequency);
  localparam int TwrClk  = Clocks(TWR, ClockFrequency);

  sdram_cmd_t cmd;
  logic [1:0] ba;
  logic       is_rd, is_wr, sel_active, do_rd, do_wr;
  logic [3:0] activate, precharge, bank_active, rcd_busy, rp_busy;
  logic [11:0] bank_row [4];
  logic [MemAddrWidth-1:0] idx;
  logic [2:0] err_src;

  assign cmd = (!bus.sdram_cs_ && bus.sdram_cke)
             ? sdram_cmd_t'({bus.sdram_ras_, bus.sdram_cas_, bus.sdram_we_}) : CmdNop;
  assign ba         = bus.sdram_ba;
  assign is_rd      = (cmd == CmdRead);
  assign is_wr      = (cmd == CmdWrite);
  assign sel_active = bank_active[ba];
  assign do_rd      = is_rd && sel_active;
  assign do_wr      = is_wr && sel_active;

  always_comb begin
    activate  = '0;
    precharge = '0;
    case (cmd)
      CmdBankActivate: activate[ba] = 1'b1;
      CmdPrecharge:    precharge = bus.sdram_a[10] ? 4'hF : (4'b0001 << ba);
      CmdRead, CmdWrite: precharge[ba] = bus.sdram_a[10];
      default: ;
    endcase
  end

  for (genvar b = 0; b < 4; b++) begin : g_bank
    sdram_responder_bank #(
      .TrcdClk(TrcdClk),
      .TrpClk (TrpClk),
      .TwrClk (TwrClk)
    ) u_bank (
      .clk        (clk),
      .rst        (rst),
      .activate   (activate[b]),
      .precharge  (precharge[b]),
      .wr_recovery(is_wr),
      .row_in     (bus.sdram_a),
      .active     (bank_active[b]),
      .row        (bank_row[b]),
      .rcd_busy   (rcd_busy[b]),
      .rp_busy    (rp_busy[b])
    );
  end

  // Bank/row bits above the array depth alias onto the same words.
  assign idx = MemAddrWidth'({ba, bank_row[ba], bus.sdram_a[8:0]});

  logic [15:0] mem [2**MemAddrWidth];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      if (!bus.sdram_ldqm) mem[idx][7:0]  <= bus.dq_in[7:0];
      if (!bus.sdram_udqm) mem[idx][15:8] <= bus.dq_in[15:8];
    end
  end

  logic [CAS-1:0] rd_valid;
  logic [15:0]    rd_data [CAS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= '0;
      for (int i = 0; i < CAS; i++) rd_data[i] <= '0;
    end else begin
      rd_valid   <= {rd_valid[CAS-2:0], do_rd};
      rd_data[0] <= do_rd ? mem[idx] : 16'd0;
      for (int i = 1; i < CAS; i++) rd_data[i] <= rd_data[i-1];
    end
  end

  assign bus.dq_out = rd_data[CAS-1];
  assign bus.dq_oe  = rd_valid[CAS-1];

`ifdef SDRAM_RESPONDER_TIMING_CHECK_EN
  localparam int TrefiClk = Clocks(TREFI, ClockFrequency);
  logic [15:0] refi_cnt;
  logic        refresh_expired;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     refi_cnt <= 16'(TrefiClk);
    else if (cmd == CmdRefresh)  refi_cnt <= 16'(TrefiClk);
    else if (refi_cnt != 16'd0)  refi_cnt <= refi_cnt - 16'd1;
  end

  assign refresh_expired = (TrefiClk != 0) && (refi_cnt == 16'd0);
`else
  localparam int unused_trefi = TREFI;
  logic unused_busy;
  assign unused_busy = ^{rcd_busy, rp_busy};
`endif

  // Chain is ordered by code so the lowest simultaneous code wins.
  always_comb begin
    err_src = ErrNone;
    if ((is_rd || is_wr) && !sel_active)                       err_src = ErrIdleBank;
    else if (cmd == CmdBankActivate && sel_active)             err_src = ErrActiveBank;
`ifdef SDRAM_RESPONDER_TIMING_CHECK_EN
    else if ((is_rd || is_wr) && rcd_busy[ba])                 err_src = ErrTrcd;
    else if (cmd == CmdBankActivate && rp_busy[ba])            err_src = ErrBankBusy;
    else if (refresh_expired || (cmd == CmdRefresh && |bank_active)) err_src = ErrRefresh;
`endif
    else if (cmd == CmdLoadMode && bus.sdram_a[6:4] != 3'(CAS)) err_src = ErrModeCas;
    else if (is_wr && rd_valid[CAS-2])                         err_src = ErrContention;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err     <= 1'b0;
      errCode <= ErrNone;
    end else if (!err && err_src != ErrNone) begin
      err     <= 1'b1;
      errCode <= err_src;
    end
  end

endmodule
